// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller input conditioning slice:
// emergency FSM state encoding and default timing constants.
package traffic_pkg;

    typedef enum logic [1:0] {
        E_IDLE    = 2'd0,
        E_ACTIVE  = 2'd1,
        E_LOCKOUT = 2'd2
    } emerg_state_e;

    localparam int unsigned DEF_CLK_HZ      = 50_000_000;
    localparam int unsigned DEF_DEB_CYCLES  = 1_000_000;
    localparam int unsigned DEF_EMERG_MIN_S = 3;
    localparam int unsigned DEF_EMERG_MAX_S = 15;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the debounced value
// follows the synchronized input only after it has differed for DEB_CYCLES clocks.
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Any return to the current debounced level restarts the stability window.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/traffic_input_cond.sv
// Conditions the raw field inputs of the traffic controller: 2 Hz / 1 Hz tick
// generation, sensor debouncing and the emergency request hold/lockout FSM.
module traffic_input_cond
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned EMERG_MIN_S = DEF_EMERG_MIN_S,
    parameter int unsigned EMERG_MAX_S = DEF_EMERG_MAX_S
) (
    input  logic clk,
    input  logic rst,
    input  logic ns_sensor_raw,
    input  logic ew_sensor_raw,
    input  logic emerg_req_raw,
    output logic tick_1hz,
    output logic tick_2hz,
    output logic ns_sensor,
    output logic ew_sensor,
    output logic emergency_trigger,
    output logic emerg_stuck
);

    localparam int unsigned HALF_HZ = CLK_HZ / 2;
    localparam int unsigned PRE_W   = $clog2(HALF_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF_HZ - 1);
    localparam int unsigned HOLD_W  = $clog2(EMERG_MAX_S + 1);
    localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(EMERG_MIN_S);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(EMERG_MAX_S);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              div_q, div_d;
    logic              tick_2hz_q, tick_2hz_d;
    logic              tick_1hz_q, tick_1hz_d;
    logic              req_deb_s;
    logic              req_prev_q, req_prev_d;
    logic              req_rise_s;
    emerg_state_e      state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              trig_q, trig_d;
    logic              stuck_q, stuck_d;

    // Ticks are registered from the next prescaler value so they line up with count == HALF_HZ-1.
    always_comb begin
        pre_d      = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        div_d      = tick_2hz_q ? ~div_q : div_q;
        tick_2hz_d = (pre_d == PRE_LAST);
        tick_1hz_d = tick_2hz_d & div_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            div_q      <= 1'b0;
            tick_2hz_q <= 1'b0;
            tick_1hz_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            div_q      <= div_d;
            tick_2hz_q <= tick_2hz_d;
            tick_1hz_q <= tick_1hz_d;
        end
    end

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ns (
        .clk (clk), .rst (rst), .raw (ns_sensor_raw), .deb (ns_sensor)
    );

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ew (
        .clk (clk), .rst (rst), .raw (ew_sensor_raw), .deb (ew_sensor)
    );

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_emerg (
        .clk (clk), .rst (rst), .raw (emerg_req_raw), .deb (req_deb_s)
    );

    assign req_rise_s = req_deb_s & ~req_prev_q;
    assign req_prev_d = req_deb_s;

    // Lockout wins over the normal release so a stuck request can never re-arm by itself.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stuck_d    = stuck_q;
        case (state_q)
            E_IDLE: begin
                if (req_rise_s) begin
                    state_d    = E_ACTIVE;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = E_IDLE;
                end
            end
            E_ACTIVE: begin
                if (tick_1hz_q && (hold_cnt_q != HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
                if (hold_cnt_q == HOLD_MAX) begin
                    state_d = E_LOCKOUT;
                    stuck_d = 1'b1;
                end else if ((hold_cnt_q >= HOLD_MIN) && !req_deb_s) begin
                    state_d = E_IDLE;
                end else begin
                    state_d = E_ACTIVE;
                end
            end
            E_LOCKOUT: begin
                if (!req_deb_s) begin
                    state_d = E_IDLE;
                end else begin
                    state_d = E_LOCKOUT;
                end
            end
            default: begin
                state_d = E_IDLE;
            end
        endcase
        trig_d = (state_d == E_ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= E_IDLE;
            hold_cnt_q <= '0;
            req_prev_q <= 1'b0;
            trig_q     <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            req_prev_q <= req_prev_d;
            trig_q     <= trig_d;
            stuck_q    <= stuck_d;
        end
    end

    assign tick_2hz          = tick_2hz_q;
    assign tick_1hz          = tick_1hz_q;
    assign emergency_trigger = trig_q;
    assign emerg_stuck       = stuck_q;

endmodule
